// File: rtl/count_seq_pkg.sv
// Shared types and helpers for the display-counter run-control sequencer.
// Terminal-count arithmetic lives here so the top and the bench agree on one definition.
package count_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } seq_state_t;

  localparam int RATE_W = 2;

  // Each rate_sel step halves the count period.
  function automatic int unsigned tc_for_rate(input int unsigned div_base,
                                              input logic [RATE_W-1:0] sel);
    return (div_base >> sel) - 32'd1;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler that flags when it has reached the current terminal count.
// hit is combinational from the register so a faster rate takes effect on the very next cycle.
module tick_prescaler
  import count_seq_pkg::*;
#(
  parameter int PW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          restart,
  input  logic [PW-1:0] tc,
  output logic          hit
);

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;

  // >= rather than == so a shrinking tc never lets the count run past it.
  assign hit = (cnt_q >= tc);

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = hit ? '0 : cnt_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/count_sequencer.sv
// Run/pause/step/clear sequencer owning the display count register.
// Emits registered one-cycle tick/wrap pulses alongside every count change.
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 1,
  parameter int WIDTH   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run_p,
  input  logic              step_p,
  input  logic              clear_p,
  input  logic              up_dn,
  input  logic [RATE_W-1:0] rate_sel,
  output logic [WIDTH-1:0]  count,
  output logic              tick,
  output logic              wrap,
  output logic              running
);

  localparam int DIV_BASE = CLK_HZ / TICK_HZ;
  localparam int PW       = $clog2(DIV_BASE);

  generate
    if (DIV_BASE < 8 || (DIV_BASE % 8) != 0) begin : g_bad_div_base
      $error("count_sequencer: CLK_HZ/TICK_HZ must be a multiple of 8 and at least 8");
    end
  endgenerate

  seq_state_t       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;
  logic             running_q, running_d;

  logic [PW-1:0]    tc;
  logic             hit;
  logic             en;
  logic             restart;
  logic             upd;

  assign tc = PW'(tc_for_rate(DIV_BASE, rate_sel));

  // The prescaler only advances in RUN cycles that are not being overridden by clear/run.
  assign en = (state_q == RUN) && !clear_p && !run_p;

  tick_prescaler #(
    .PW(PW)
  ) u_prescaler (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .restart (restart),
    .tc      (tc),
    .hit     (hit)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    restart = 1'b0;
    upd     = 1'b0;

    if (clear_p) begin
      state_d = IDLE;
      count_d = '0;
      restart = 1'b1;
    end else if (run_p) begin
      if (state_q == RUN) begin
        state_d = PAUSE;
      end else begin
        state_d = RUN;
        restart = 1'b1;
      end
    end else if (step_p && state_q != RUN) begin
      state_d = PAUSE;
      upd     = 1'b1;
    end else if (state_q == RUN && hit) begin
      upd = 1'b1;
    end

    if (upd) begin
      tick_d = 1'b1;
      if (up_dn) begin
        count_d = count_q + WIDTH'(1);
        wrap_d  = &count_q;
      end else begin
        count_d = count_q - WIDTH'(1);
        wrap_d  = ~|count_q;
      end
    end

    running_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      tick_q    <= 1'b0;
      wrap_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      tick_q    <= tick_d;
      wrap_q    <= wrap_d;
      running_q <= running_d;
    end
  end

  assign count   = count_q;
  assign tick    = tick_q;
  assign wrap    = wrap_q;
  assign running = running_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Self-checking bench for count_sequencer with DIV_BASE=16 (CLK_HZ=16, TICK_HZ=1).
// Directed scenarios use hand-derived constants; random traffic is checked against a behavioural model.
module tb_count_sequencer;

  localparam int MODEL_DIV  = 16;
  localparam int MODE_IDLE  = 0;
  localparam int MODE_RUN   = 1;
  localparam int MODE_PAUSE = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run_p;
  logic       step_p;
  logic       clear_p;
  logic       up_dn;
  logic [1:0] rate_sel;
  logic [7:0] count;
  logic       tick;
  logic       wrap;
  logic       running;

  int vectors     = 0;
  int miscompares = 0;

  int m_mode;
  int m_ps;
  int m_count;
  bit m_tick;
  bit m_wrap;

  count_sequencer #(
    .CLK_HZ  (16),
    .TICK_HZ (1),
    .WIDTH   (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .run_p    (run_p),
    .step_p   (step_p),
    .clear_p  (clear_p),
    .up_dn    (up_dn),
    .rate_sel (rate_sel),
    .count    (count),
    .tick     (tick),
    .wrap     (wrap),
    .running  (running)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_mode  = MODE_IDLE;
    m_ps    = 0;
    m_count = 0;
    m_tick  = 0;
    m_wrap  = 0;
  endtask

  // Behavioural rules: priority clear > run > step, period (16>>rate) cycles, modular count.
  task automatic model_edge(input bit r, input bit s, input bit c, input bit ud, input int rs);
    int tc;
    bit upd;
    tc     = (MODEL_DIV >> rs) - 1;
    upd    = 0;
    m_tick = 0;
    m_wrap = 0;
    if (c) begin
      m_mode  = MODE_IDLE;
      m_count = 0;
      m_ps    = 0;
    end else if (r) begin
      if (m_mode == MODE_RUN) m_mode = MODE_PAUSE;
      else begin
        m_mode = MODE_RUN;
        m_ps   = 0;
      end
    end else if (s && m_mode != MODE_RUN) begin
      m_mode = MODE_PAUSE;
      upd    = 1;
    end else if (m_mode == MODE_RUN) begin
      if (m_ps >= tc) begin
        m_ps = 0;
        upd  = 1;
      end else begin
        m_ps = m_ps + 1;
      end
    end
    if (upd) begin
      m_tick = 1;
      if (ud) begin
        m_wrap  = (m_count == 255);
        m_count = (m_count + 1) % 256;
      end else begin
        m_wrap  = (m_count == 0);
        m_count = (m_count + 255) % 256;
      end
    end
  endtask

  task automatic apply(input logic r, input logic s, input logic c, input logic ud, input logic [1:0] rs);
    run_p    = r;
    step_p   = s;
    clear_p  = c;
    up_dn    = ud;
    rate_sel = rs;
    @(posedge clk);
    model_edge(r, s, c, ud, int'(rs));
    #1;
    run_p   = 1'b0;
    step_p  = 1'b0;
    clear_p = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    run_p = 1'b0; step_p = 1'b0; clear_p = 1'b0; up_dn = 1'b1; rate_sel = 2'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({count, tick, wrap, running} !== 11'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_values: got count=%0d tick=%0b wrap=%0b running=%0b, want all 0",
               count, tick, wrap, running);
    end
    @(negedge clk);
    rst_n = 1'b1;
    apply(0, 0, 0, 1, 0);
    vectors++;
    if ({count, tick, wrap, running} !== 11'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_idle_hold: got count=%0d tick=%0b wrap=%0b running=%0b, want all 0",
               count, tick, wrap, running);
    end
  endtask

  task automatic test_run_basic();
    logic [7:0] exp_count;
    logic       exp_tick;
    apply(1, 0, 0, 1, 0);
    vectors++;
    if ({count, tick, running} !== {8'd0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL run_entry: got count=%0d tick=%0b running=%0b, want count=0 tick=0 running=1",
               count, tick, running);
    end
    for (int i = 1; i <= 48; i++) begin
      apply(0, 0, 0, 1, 0);
      exp_count = 8'(i / 16);
      exp_tick  = (i % 16 == 0);
      vectors++;
      if ({count, tick, wrap, running} !== {exp_count, exp_tick, 1'b0, 1'b1}) begin
        miscompares++;
        $display("[TB] FAIL run_basic cyc %0d: got count=%0d tick=%0b wrap=%0b running=%0b, want count=%0d tick=%0b wrap=0 running=1",
                 i, count, tick, wrap, running, exp_count, exp_tick);
      end
    end
    apply(1, 0, 0, 1, 0);
    vectors++;
    if ({count, tick, running} !== {8'd3, 1'b0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL run_pause: got count=%0d tick=%0b running=%0b, want count=3 tick=0 running=0",
               count, tick, running);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] up_cnt [4] = '{8'd254, 8'd255, 8'd255, 8'd0};
    logic [7:0] dn_cnt [4] = '{8'd1, 8'd0, 8'd0, 8'd255};
    logic       exp_tk [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic       exp_wr [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    apply(0, 0, 1, 1, 0);
    repeat (254) apply(0, 1, 0, 1, 0);
    vectors++;
    if ({count, running} !== {8'd254, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL wrap_preset: got count=%0d running=%0b, want count=254 running=0", count, running);
    end
    apply(1, 0, 0, 1, 3);
    for (int k = 0; k < 4; k++) begin
      apply(0, 0, 0, 1, 3);
      vectors++;
      if ({count, tick, wrap} !== {up_cnt[k], exp_tk[k], exp_wr[k]}) begin
        miscompares++;
        $display("[TB] FAIL wrap_up cyc %0d: got count=%0d tick=%0b wrap=%0b, want count=%0d tick=%0b wrap=%0b",
                 k + 1, count, tick, wrap, up_cnt[k], exp_tk[k], exp_wr[k]);
      end
    end
    apply(0, 0, 1, 1, 0);
    apply(0, 1, 0, 1, 0);
    apply(1, 0, 0, 0, 3);
    for (int k = 0; k < 4; k++) begin
      apply(0, 0, 0, 0, 3);
      vectors++;
      if ({count, tick, wrap} !== {dn_cnt[k], exp_tk[k], exp_wr[k]}) begin
        miscompares++;
        $display("[TB] FAIL wrap_down cyc %0d: got count=%0d tick=%0b wrap=%0b, want count=%0d tick=%0b wrap=%0b",
                 k + 1, count, tick, wrap, dn_cnt[k], exp_tk[k], exp_wr[k]);
      end
    end
    apply(1, 0, 0, 1, 0);
  endtask

  task automatic test_rate_change();
    logic [7:0] exp_count;
    logic       exp_tick;
    apply(0, 0, 1, 1, 0);
    apply(1, 0, 0, 1, 0);
    repeat (10) apply(0, 0, 0, 1, 0);
    for (int k = 1; k <= 6; k++) begin
      apply(0, 0, 0, 1, 3);
      exp_count = 8'((k + 1) / 2);
      exp_tick  = (k % 2 == 1);
      vectors++;
      if ({count, tick, running} !== {exp_count, exp_tick, 1'b1}) begin
        miscompares++;
        $display("[TB] FAIL rate_change cyc %0d: got count=%0d tick=%0b running=%0b, want count=%0d tick=%0b running=1",
                 k, count, tick, running, exp_count, exp_tick);
      end
    end
    apply(0, 0, 1, 1, 0);
  endtask

  task automatic test_step();
    for (int j = 1; j <= 3; j++) begin
      apply(0, 1, 0, 1, 0);
      vectors++;
      if ({count, tick, running} !== {8'(j), 1'b1, 1'b0}) begin
        miscompares++;
        $display("[TB] FAIL step_idle %0d: got count=%0d tick=%0b running=%0b, want count=%0d tick=1 running=0",
                 j, count, tick, running, j);
      end
      apply(0, 0, 0, 1, 0);
      vectors++;
      if ({count, tick} !== {8'(j), 1'b0}) begin
        miscompares++;
        $display("[TB] FAIL step_gap %0d: got count=%0d tick=%0b, want count=%0d tick=0", j, count, tick, j);
      end
    end
    apply(1, 0, 0, 1, 0);
    apply(0, 1, 0, 1, 0);
    vectors++;
    if ({count, tick, running} !== {8'd3, 1'b0, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL step_in_run: got count=%0d tick=%0b running=%0b, want count=3 tick=0 running=1",
               count, tick, running);
    end
    apply(0, 0, 1, 1, 0);
  endtask

  task automatic test_priority();
    repeat (7) apply(0, 1, 0, 1, 0);
    apply(1, 0, 0, 1, 0);
    repeat (3) apply(0, 0, 0, 1, 0);
    apply(1, 1, 1, 1, 0);
    vectors++;
    if ({count, tick, wrap, running} !== {8'd0, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL prio_clear: got count=%0d tick=%0b wrap=%0b running=%0b, want count=0 tick=0 wrap=0 running=0",
               count, tick, wrap, running);
    end
    apply(1, 0, 0, 1, 0);
    repeat (15) apply(0, 0, 0, 1, 0);
    apply(1, 0, 0, 1, 0);
    vectors++;
    if ({count, tick, running} !== {8'd0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL prio_run_on_tc: got count=%0d tick=%0b running=%0b, want count=0 tick=0 running=0",
               count, tick, running);
    end
    for (int k = 0; k < 20; k++) begin
      apply((k == 2), 0, 0, 1, 0);
      vectors++;
      if ({count, tick, wrap, running} !== {m_count[7:0], m_tick, m_wrap, m_mode == MODE_RUN}) begin
        miscompares++;
        $display("[TB] FAIL prio_resume cyc %0d: got count=%0d tick=%0b wrap=%0b running=%0b, want count=%0d tick=%0b wrap=%0b running=%0b",
                 k, count, tick, wrap, running, m_count, m_tick, m_wrap, m_mode == MODE_RUN);
      end
    end
    apply(0, 0, 1, 1, 0);
  endtask

  task automatic test_async_reset();
    repeat (5) apply(0, 1, 0, 1, 0);
    apply(1, 0, 0, 1, 0);
    repeat (4) apply(0, 0, 0, 1, 0);
    vectors++;
    if ({count, running} !== {8'd5, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL areset_pre: got count=%0d running=%0b, want count=5 running=1", count, running);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    vectors++;
    if ({count, tick, wrap, running} !== 11'b0) begin
      miscompares++;
      $display("[TB] FAIL areset_immediate: got count=%0d tick=%0b wrap=%0b running=%0b, want all 0",
               count, tick, wrap, running);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    apply(0, 0, 0, 1, 0);
    vectors++;
    if ({count, tick, running} !== {8'd0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL areset_release: got count=%0d tick=%0b running=%0b, want count=0 tick=0 running=0",
               count, tick, running);
    end
    apply(0, 1, 0, 1, 0);
    vectors++;
    if ({count, tick, running} !== {8'd1, 1'b1, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL areset_step_after: got count=%0d tick=%0b running=%0b, want count=1 tick=1 running=0",
               count, tick, running);
    end
  endtask

  task automatic test_random();
    logic       r, s, c, ud;
    logic [1:0] rs;
    ud = 1'b1;
    rs = 2'd2;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) < 3) rs = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) < 5) ud = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 59) == 0);
      s = ($urandom_range(0, 9) == 0);
      c = ($urandom_range(0, 199) == 0);
      apply(r, s, c, ud, rs);
      vectors++;
      if ({count, tick, wrap, running} !== {m_count[7:0], m_tick, m_wrap, m_mode == MODE_RUN}) begin
        miscompares++;
        $display("[TB] FAIL random cyc %0d: got count=%0d tick=%0b wrap=%0b running=%0b, want count=%0d tick=%0b wrap=%0b running=%0b",
                 n, count, tick, wrap, running, m_count, m_tick, m_wrap, m_mode == MODE_RUN);
      end
    end
  endtask

  initial begin
    test_reset();
    test_run_basic();
    test_wrap();
    test_rate_change();
    test_step();
    test_priority();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/count_sequencer.md
# count_sequencer

Run-control sequencer for the board's 8-bit display counter. It sits between the debounced push-button pulses and the counter/seven-segment datapath. It replaces the free-running toggled slow clock with single-cycle tick enables in the `clk` domain, at a selectable rate. It also provides a run/pause/step/clear state machine that owns the count register fed to the SSD decoder.

## Interface
- `CLK_HZ`, 100_000_000: frequency of `clk`.
- `TICK_HZ`, 1: base count rate when `rate_sel`=0.
- `WIDTH`, 8: count width.
- `clk` in 1: system clock; all logic on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `run_p` in 1: single-cycle start/stop pulse, already debounced and synchronized.
- `step_p` in 1: single-cycle pulse; advances the count by one while not running.
- `clear_p` in 1: single-cycle pulse; zeroes the count and returns to IDLE.
- `up_dn` in 1: level; 1 = count up, 0 = count down.
- `rate_sel` in 2: rate select; count period = DIV_BASE >> `rate_sel` clocks.
- `count` out WIDTH: current count value, goes to the SSD decoder.
- `tick` out 1: one-cycle pulse, coincident with every `count` change.
- `wrap` out 1: one-cycle pulse when the count wraps.
- `running` out 1: high in the RUN state.

## Operation
- DIV_BASE = CLK_HZ/TICK_HZ. Elaboration error if DIV_BASE < 8 or DIV_BASE is not a multiple of 8.
- Prescaler width is $clog2(DIV_BASE).
- Terminal count TC = (DIV_BASE >> rate_sel) - 1. `rate_sel` is sampled every cycle.
- States: IDLE, RUN, PAUSE. Reset enters IDLE.
- Input priority each cycle: `clear_p` > `run_p` > `step_p`. Lower-priority pulses in the same cycle are dropped.
- `clear_p` in any state: go to IDLE, count <= 0, prescaler <= 0, no `tick`, no `wrap`.
- `run_p`:
  - IDLE -> RUN and PAUSE -> RUN; prescaler <= 0 on entry.
  - RUN -> PAUSE; prescaler holds its value but is cleared on the next RUN entry.
- `step_p`:
  - IDLE -> PAUSE, with one count update.
  - PAUSE: stays PAUSE, with one count update.
  - RUN: ignored.
- In RUN the prescaler increments every cycle. When prescaler >= TC: prescaler <= 0 and a count update occurs. The `>=` compare covers a `rate_sel` change to a faster rate; the update then fires on the next cycle.
- Count update, up: count <= count + 1 mod 2^WIDTH; `wrap` asserts when 255 -> 0.
- Count update, down: count <= count - 1 mod 2^WIDTH; `wrap` asserts when 0 -> 255.
- `up_dn` is sampled in the update cycle.
- In IDLE and PAUSE the count is frozen and the prescaler is static.

## Timing
- Reset values: `count`=0, `tick`=0, `wrap`=0, `running`=0, prescaler=0, state IDLE.
- All outputs are registered; no combinational path from inputs to outputs.
- Update latency: the update condition in cycle N (prescaler >= TC, or an accepted `step_p`) gives new `count`, `tick`=1 and `wrap` (if wrapping) in cycle N+1, all for exactly one cycle.
- `running` rises/falls in the cycle after the accepted `run_p`.
- First tick after entering RUN: TC+1 cycles after the `run_p` cycle. Ticks then repeat every TC+1 cycles.
- `run_p` coinciding with a terminal-count cycle in RUN: the state goes to PAUSE and the update is suppressed (priority).
- `rst_n` deassertion mid-operation is not special-cased. Assertion is asynchronous and immediately forces the reset values. The release is assumed synchronized upstream.

## Structure
- Package `count_seq_pkg`:
  - state enum `seq_state_t` {IDLE, RUN, PAUSE};
  - `RATE_W`=2;
  - function `tc_for_rate(div_base, sel)`.
- One sub-module, `tick_prescaler`:
  - inputs: `clk`, `rst_n`, `en`, `restart`, `tc`;
  - output: `hit`, combinational from the registered prescaler.
- The FSM, count register and output registers live in `count_sequencer`.

## Test plan
All scenarios use CLK_HZ=16, TICK_HZ=1, so DIV_BASE=16.
- Reset, `run_p`, `rate_sel`=0, `up_dn`=1 -> `running`=1 next cycle; `tick` every 16 cycles, first 16 cycles after `run_p`; `count` 1, 2, 3.
- Count preset to 254 via steps, then RUN -> `count` 255 then 0; `wrap`=1 only on the 0 cycle. Repeat with `up_dn`=0 from 1 -> 0 then 255, `wrap` on the 255 cycle.
- `rate_sel` 0 -> 3 when prescaler=10 -> tick on the next cycle, then every 2 cycles.
- In IDLE: `step_p` x3 -> `count`=3, state PAUSE, `running`=0, three `tick` pulses. `step_p` in RUN -> no change.
- `clear_p`+`run_p`+`step_p` in the same cycle while RUN at count 7 -> `count`=0, IDLE, no tick. `run_p` on a terminal cycle -> PAUSE, no tick.
- `rst_n` low mid-RUN at count 5 -> all outputs 0 immediately (asynchronous), IDLE after release.
